// File: rtl/slurm16_pkg.sv
// Shared types and constants for the slurm16 memory model.
package slurm16_pkg;

  // Feedback taps 16,14,13,11 of a right-shifting Fibonacci LFSR (bit 0 shifts out).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  // Byte-enable encodings: bit0 = [7:0], bit1 = [15:8].
  localparam logic [1:0] MASK_LO   = 2'b01;
  localparam logic [1:0] MASK_HI   = 2'b10;
  localparam logic [1:0] MASK_WORD = 2'b11;

  typedef logic [14:0] word_addr_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  // Merge store data into the old word under the byte mask; mask 00 keeps the old word.
  function automatic logic [15:0] byte_merge(input logic [15:0] old_word,
                                             input logic [15:0] new_word,
                                             input logic [1:0]  mask);
    logic [15:0] res;
    unique case (mask)
      MASK_WORD: res = new_word;
      MASK_LO:   res = {old_word[15:8], new_word[7:0]};
      MASK_HI:   res = {new_word[15:8], old_word[7:0]};
      default:   res = old_word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/slurm16_wait_gen.sv
// Per-port wait-state generator: accepts a held request after WAIT cycles, unless stalled.
module slurm16_wait_gen #(
  parameter int unsigned WAIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic stall,
  output logic acc
);

  localparam logic [3:0] WaitInit = 4'(WAIT);

  logic [3:0] cnt_q, cnt_d;

  // Acceptance and counter next state; the counter freezes while the request is low.
  always_comb begin
    acc   = req && (cnt_q == 4'd0) && !stall;
    cnt_d = cnt_q;
    if (acc) begin
      cnt_d = WaitInit;
    end else if (req && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Counter register; reset discards pending waits.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= WaitInit;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/slurm16_mem_model.sv
// Instruction/data memory model with wait states, random stalls and optional single-port mode.
module slurm16_mem_model
  import slurm16_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 7,
  parameter int unsigned IWAIT      = 0,
  parameter int unsigned DWAIT      = 0,
  parameter bit          SHARED     = 1'b0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter string       INIT_FILE  = ""
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        instruction_request,
  input  word_addr_t  instruction_address,
  output logic [15:0] instruction_in,
  output word_addr_t  instruction_address_in,
  output logic        instruction_valid,
  input  logic        load_memory,
  input  logic        store_memory,
  input  word_addr_t  load_store_address,
  input  logic [15:0] memory_out,
  input  logic [1:0]  memory_mask,
  output logic [15:0] memory_in,
  output logic        memory_request_successful,
  input  logic        rand_stall_en
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [15:0] mem [0:Depth-1];
  logic [15:0] lfsr_q;
  logic [DEPTH_LOG2-1:0] iidx, didx;
  logic dreq, dacc, facc, dstall, fstall;

  assign iidx = instruction_address[DEPTH_LOG2-1:0];
  assign didx = load_store_address[DEPTH_LOG2-1:0];

  // Upper address bits alias away.
  if (DEPTH_LOG2 < 15) begin : g_unused_addr
    logic unused_addr_bits;
    assign unused_addr_bits = ^{instruction_address[14:DEPTH_LOG2],
                                load_store_address[14:DEPTH_LOG2]};
  end

  // Contents start at zero and are never reset.
  initial begin
    for (int i = 0; i < Depth; i++) mem[i] = 16'h0000;
  end

  // Stall sources; in single-port mode a data request blocks the fetch.
  always_comb begin
    dreq   = load_memory || store_memory;
    dstall = rand_stall_en && (lfsr_q[1:0] == 2'b00);
    fstall = (rand_stall_en && (lfsr_q[3:2] == 2'b00)) || (SHARED && dreq);
  end

  slurm16_wait_gen #(.WAIT(DWAIT)) u_dwait (
    .clk   (CLK),
    .rst   (RST),
    .req   (dreq),
    .stall (dstall),
    .acc   (dacc)
  );

  slurm16_wait_gen #(.WAIT(IWAIT)) u_iwait (
    .clk   (CLK),
    .rst   (RST),
    .req   (instruction_request),
    .stall (fstall),
    .acc   (facc)
  );

  assign memory_request_successful = dacc;

  // Free-running stall LFSR.
  always_ff @(posedge CLK) begin
    if (RST) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_next(lfsr_q);
  end

  // Byte-masked store; reads in the same cycle see the old word.
  always_ff @(posedge CLK) begin
    if (dacc && store_memory) mem[didx] <= byte_merge(mem[didx], memory_out, memory_mask);
  end

  // Load data capture; a simultaneous store suppresses the load update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      memory_in <= 16'h0000;
    end else if (dacc && load_memory && !store_memory) begin
      memory_in <= mem[didx];
    end
  end

  // Fetch response register; data and address hold when no fetch is accepted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instruction_in         <= 16'h0000;
      instruction_address_in <= '0;
      instruction_valid      <= 1'b0;
    end else begin
      instruction_valid <= facc;
      if (facc) begin
        instruction_in         <= mem[iidx];
        instruction_address_in <= instruction_address;
      end
    end
  end

endmodule

// File: tb/tb_slurm16_mem_model.sv
// Directed self-checking bench for slurm16_mem_model: a split-port instance and a shared one.
module tb_slurm16_mem_model;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: IWAIT=0, DWAIT=3, split ports, seed 1.
  logic        a_ireq, a_ivalid, a_ld, a_st, a_mrs, a_rse;
  logic [14:0] a_iaddr, a_iaddr_in, a_addr;
  logic [15:0] a_iin, a_wdata, a_rdata;
  logic [1:0]  a_mask;

  // Instance B: no waits, shared port.
  logic        b_ireq, b_ivalid, b_ld, b_st, b_mrs, b_rse;
  logic [14:0] b_iaddr, b_iaddr_in, b_addr;
  logic [15:0] b_iin, b_wdata, b_rdata;
  logic [1:0]  b_mask;

  slurm16_mem_model #(.DEPTH_LOG2(7), .IWAIT(0), .DWAIT(3), .SHARED(0),
                      .LFSR_SEED(16'h0001)) u_a (
    .CLK                       (clk),
    .RST                       (rst),
    .instruction_request       (a_ireq),
    .instruction_address       (a_iaddr),
    .instruction_in            (a_iin),
    .instruction_address_in    (a_iaddr_in),
    .instruction_valid         (a_ivalid),
    .load_memory               (a_ld),
    .store_memory              (a_st),
    .load_store_address        (a_addr),
    .memory_out                (a_wdata),
    .memory_mask               (a_mask),
    .memory_in                 (a_rdata),
    .memory_request_successful (a_mrs),
    .rand_stall_en             (a_rse)
  );

  slurm16_mem_model #(.DEPTH_LOG2(7), .IWAIT(0), .DWAIT(0), .SHARED(1)) u_b (
    .CLK                       (clk),
    .RST                       (rst),
    .instruction_request       (b_ireq),
    .instruction_address       (b_iaddr),
    .instruction_in            (b_iin),
    .instruction_address_in    (b_iaddr_in),
    .instruction_valid         (b_ivalid),
    .load_memory               (b_ld),
    .store_memory              (b_st),
    .load_store_address        (b_addr),
    .memory_out                (b_wdata),
    .memory_mask               (b_mask),
    .memory_in                 (b_rdata),
    .memory_request_successful (b_mrs),
    .rand_stall_en             (b_rse)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference LFSR: taps 16,14,13,11, shifting right, reloaded on reset.
  logic [15:0] m_lfsr;
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'h0001;
    else     m_lfsr <= (m_lfsr >> 1) |
                       (16'(m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5]) << 15);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a data request on A from a negedge until accepted; returns on the negedge after.
  task automatic a_access(input logic ld, input logic st, input logic [14:0] addr,
                          input logic [15:0] data, input logic [1:0] mask);
    int n;
    n = 0;
    a_ld = ld; a_st = st; a_addr = addr; a_wdata = data; a_mask = mask;
    #1;
    while (!a_mrs && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (!a_mrs) check("data_accept_timeout", 32'(a_mrs), 32'd1);
    @(negedge clk);
    a_ld = 1'b0; a_st = 1'b0;
  endtask

  // Hold a load on A for four cycles from a negedge and collect the acceptance pattern.
  task automatic a_wait_load(input logic [14:0] addr, output logic [3:0] pat);
    a_ld = 1'b1; a_addr = addr;
    for (int k = 0; k < 4; k++) begin
      #1; pat[k] = a_mrs;
      @(negedge clk);
    end
    a_ld = 1'b0;
  endtask

  logic [15:0] img [3];
  logic [3:0]  pat;
  int issue, deliver, obs_stall, mdl_stall, order_err, pred_err;
  logic pred;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    img[0] = 16'h3013; img[1] = 16'h3027; img[2] = 16'h2112;
    rst = 1'b1;
    a_ireq = 0; a_iaddr = 0; a_ld = 0; a_st = 0; a_addr = 0; a_wdata = 0; a_mask = 0; a_rse = 0;
    b_ireq = 0; b_iaddr = 0; b_ld = 0; b_st = 0; b_addr = 0; b_wdata = 0; b_mask = 0; b_rse = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_iin", 32'(a_iin), 32'h0);
    check("rst_iaddr_in", 32'(a_iaddr_in), 32'h0);
    check("rst_ivalid", 32'(a_ivalid), 32'h0);
    check("rst_mem_in", 32'(a_rdata), 32'h0);
    @(negedge clk);

    // Preload image through full-word stores.
    for (int k = 0; k < 3; k++) a_access(1'b0, 1'b1, 15'(k), img[k], 2'b11);
    a_access(1'b0, 1'b1, 15'd5, 16'hBEEF, 2'b11);
    a_access(1'b0, 1'b1, 15'd9, 16'h1234, 2'b11);

    // Back-to-back fetch, one word per cycle.
    a_ireq = 1'b1; a_iaddr = 15'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("b2b_valid", 32'(a_ivalid), 32'd1);
      check("b2b_data", 32'(a_iin), 32'(img[k]));
      check("b2b_addr", 32'(a_iaddr_in), 32'(k));
      a_iaddr = 15'(k + 1);
    end
    a_ireq = 1'b0;
    @(negedge clk);
    check("fetch_idle_valid", 32'(a_ivalid), 32'd0);
    check("fetch_idle_hold", 32'(a_iin), 32'h2112);

    // Data wait states: accepted on the 4th held cycle only.
    a_wait_load(15'd5, pat);
    check("dwait_pattern", 32'(pat), 32'b1000);
    check("dwait_data", 32'(a_rdata), 32'hBEEF);

    // Reset with dcnt=2 mid-load.
    a_ld = 1'b1; a_addr = 15'd5;
    @(negedge clk); #1;
    check("mid_not_acc", 32'(a_mrs), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_ld = 1'b0;
    #1;
    check("mid_rst_iin", 32'(a_iin), 32'h0);
    check("mid_rst_iaddr_in", 32'(a_iaddr_in), 32'h0);
    check("mid_rst_ivalid", 32'(a_ivalid), 32'h0);
    check("mid_rst_mem_in", 32'(a_rdata), 32'h0);
    @(negedge clk);
    a_wait_load(15'd5, pat);
    check("post_rst_pattern", 32'(pat), 32'b1000);
    check("post_rst_data", 32'(a_rdata), 32'hBEEF);

    // Byte-masked stores on mem[9]=1234 (kept through reset).
    a_access(1'b0, 1'b1, 15'd9, 16'hABCD, 2'b01);
    a_access(1'b0, 1'b1, 15'd9, 16'h5600, 2'b10);
    a_access(1'b1, 1'b0, 15'd9, 16'h0000, 2'b00);
    check("mask_merge", 32'(a_rdata), 32'h56CD);
    a_access(1'b0, 1'b1, 15'd9, 16'hFFFF, 2'b00);
    a_access(1'b1, 1'b0, 15'd9, 16'h0000, 2'b00);
    check("mask_none", 32'(a_rdata), 32'h56CD);

    // Simultaneous load and store: store wins, memory_in holds.
    a_access(1'b1, 1'b1, 15'd9, 16'h0000, 2'b11);
    check("ldst_hold", 32'(a_rdata), 32'h56CD);
    a_access(1'b1, 1'b0, 15'd9, 16'h0000, 2'b00);
    check("ldst_stored", 32'(a_rdata), 32'h0000);

    // Address aliasing: 0x0085 maps to word 5.
    a_access(1'b1, 1'b0, 15'h0085, 16'h0000, 2'b00);
    check("wrap_load", 32'(a_rdata), 32'hBEEF);

    // Random stalls on a 200-cycle sequential fetch stream.
    a_rse = 1'b1; a_ireq = 1'b1;
    issue = 0; deliver = 0; obs_stall = 0; mdl_stall = 0; order_err = 0; pred_err = 0;
    for (int c = 0; c < 200; c++) begin
      a_iaddr = 15'(issue);
      #1;
      pred = (m_lfsr[3:2] != 2'b00);
      if (!pred) mdl_stall++;
      @(negedge clk);
      if (a_ivalid !== pred) pred_err++;
      if (a_ivalid) begin
        if (a_iaddr_in != 15'(deliver)) order_err++;
        deliver++;
        issue++;
      end else begin
        obs_stall++;
      end
    end
    a_rse = 1'b0; a_ireq = 1'b0;
    check("rand_stall_count", 32'(obs_stall), 32'(mdl_stall));
    check("rand_cycle_match", 32'(pred_err), 32'd0);
    check("rand_order", 32'(order_err), 32'd0);
    check("rand_delivered", 32'(deliver), 32'(200 - mdl_stall));

    // Shared port: load beats fetch, fetch follows next cycle.
    @(negedge clk);
    b_ireq = 1'b1; b_iaddr = 15'd7; b_ld = 1'b1; b_addr = 15'd3;
    #1;
    check("shared_load_acc", 32'(b_mrs), 32'd1);
    @(negedge clk);
    check("shared_fetch_blocked", 32'(b_ivalid), 32'd0);
    b_ld = 1'b0;
    @(negedge clk);
    check("shared_fetch_valid", 32'(b_ivalid), 32'd1);
    check("shared_fetch_addr", 32'(b_iaddr_in), 32'd7);
    b_ireq = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
